// File: rtl/wb_gpio_pkg.sv
// Shared constants for the Wishbone GPIO slave: register map, ID, reset values
// and the split of the IO vector into a 32-bit low word and a narrow high word.
package wb_gpio_pkg;

    localparam int GPIO_NUM_IO = 38;
    localparam int LO_WIDTH    = 32;

    localparam logic [7:0] OFF_OUT_LO = 8'h00;
    localparam logic [7:0] OFF_OUT_HI = 8'h04;
    localparam logic [7:0] OFF_OEB_LO = 8'h08;
    localparam logic [7:0] OFF_OEB_HI = 8'h0C;
    localparam logic [7:0] OFF_IN_LO  = 8'h10;
    localparam logic [7:0] OFF_IN_HI  = 8'h14;
    localparam logic [7:0] OFF_IEN_LO = 8'h18;
    localparam logic [7:0] OFF_IEN_HI = 8'h1C;
    localparam logic [7:0] OFF_IST_LO = 8'h20;
    localparam logic [7:0] OFF_IST_HI = 8'h24;
    localparam logic [7:0] OFF_ID     = 8'h28;

    localparam logic [31:0] GPIO_ID = 32'h4750_494F;

    // Pads come out of reset as inputs with their output data low.
    localparam logic [GPIO_NUM_IO-1:0] OUT_RST_VAL = '0;
    localparam logic [GPIO_NUM_IO-1:0] OEB_RST_VAL = '1;

    // Edge detection stays masked until the arm counter reaches this value.
    localparam logic [1:0] ARM_DONE = 2'd3;

    // Width of the high word for a given IO count.
    function automatic int hi_width(input int num_io);
        return num_io - LO_WIDTH;
    endfunction

    // Expand the four byte enables into a 32-bit bit mask.
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // Replace only the masked bits of a register word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Brings asynchronous pad inputs into the clock domain and flags rising edges.
// Edges are masked for the first few cycles after reset so that pins already
// high while reset is held do not look like fresh edges.
module gpio_sync_edge
    import wb_gpio_pkg::*;
#(
    parameter int WIDTH  = 38,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [WIDTH-1:0]             prev_q;
    logic [1:0]                   arm_cnt;

    // Synchroniser chain, previous-value flop and the post-reset arm counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= '0;
            arm_cnt <= 2'd0;
        end else begin
            chain_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            prev_q <= chain_q[STAGES-1];
            if (arm_cnt != ARM_DONE) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

    assign sync = chain_q[STAGES-1];
    assign rise = sync & ~prev_q & {WIDTH{arm_cnt == ARM_DONE}};

endmodule

// File: rtl/wb_gpio_slave.sv
// Wishbone classic slave exposing the user IOs as output, output-enable,
// synchronised input and rising-edge interrupt registers.
module wb_gpio_slave
    import wb_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NUM_IO      = GPIO_NUM_IO,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic [2:0]        user_irq
);

    localparam int HI_W = hi_width(NUM_IO);

    logic              hit, req, wr, ack_q, irq_q;
    logic [7:0]        offset;
    logic [31:0]       wmask, rdata, dat_q;
    logic [NUM_IO-1:0] out_q, oeb_q, ien_q, ist_q;
    logic [NUM_IO-1:0] out_next, oeb_next, ien_next, ist_next, w1c;
    logic [NUM_IO-1:0] in_sync, rise;

    assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req    = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
    assign wr     = req & wbs_we_i;
    assign offset = wbs_adr_i[7:0];
    assign wmask  = sel_to_mask(wbs_sel_i);

    gpio_sync_edge #(
        .WIDTH  (NUM_IO),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .din   (io_in),
        .sync  (in_sync),
        .rise  (rise)
    );

    // Next value of every writable register, honouring byte enables.
    always_comb begin
        out_next = out_q;
        oeb_next = oeb_q;
        ien_next = ien_q;
        w1c      = '0;
        if (wr) begin
            case (offset)
                OFF_OUT_LO: out_next[LO_WIDTH-1:0] = merge_bytes(out_q[LO_WIDTH-1:0], wbs_dat_i, wmask);
                OFF_OUT_HI: out_next[NUM_IO-1:LO_WIDTH] = (out_q[NUM_IO-1:LO_WIDTH] & ~wmask[HI_W-1:0])
                                                        | (wbs_dat_i[HI_W-1:0] & wmask[HI_W-1:0]);
                OFF_OEB_LO: oeb_next[LO_WIDTH-1:0] = merge_bytes(oeb_q[LO_WIDTH-1:0], wbs_dat_i, wmask);
                OFF_OEB_HI: oeb_next[NUM_IO-1:LO_WIDTH] = (oeb_q[NUM_IO-1:LO_WIDTH] & ~wmask[HI_W-1:0])
                                                        | (wbs_dat_i[HI_W-1:0] & wmask[HI_W-1:0]);
                OFF_IEN_LO: ien_next[LO_WIDTH-1:0] = merge_bytes(ien_q[LO_WIDTH-1:0], wbs_dat_i, wmask);
                OFF_IEN_HI: ien_next[NUM_IO-1:LO_WIDTH] = (ien_q[NUM_IO-1:LO_WIDTH] & ~wmask[HI_W-1:0])
                                                        | (wbs_dat_i[HI_W-1:0] & wmask[HI_W-1:0]);
                OFF_IST_LO: w1c[LO_WIDTH-1:0] = wbs_dat_i & wmask;
                OFF_IST_HI: w1c[NUM_IO-1:LO_WIDTH] = wbs_dat_i[HI_W-1:0] & wmask[HI_W-1:0];
                default: ;
            endcase
        end
        // A new edge outranks a clear landing on the same bit in the same cycle.
        ist_next = (ist_q & ~w1c) | (rise & ien_q);
    end

    // Read mux; high words are zero-extended and unmapped offsets read zero.
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_OUT_LO: rdata = out_q[LO_WIDTH-1:0];
            OFF_OUT_HI: rdata[HI_W-1:0] = out_q[NUM_IO-1:LO_WIDTH];
            OFF_OEB_LO: rdata = oeb_q[LO_WIDTH-1:0];
            OFF_OEB_HI: rdata[HI_W-1:0] = oeb_q[NUM_IO-1:LO_WIDTH];
            OFF_IN_LO:  rdata = in_sync[LO_WIDTH-1:0];
            OFF_IN_HI:  rdata[HI_W-1:0] = in_sync[NUM_IO-1:LO_WIDTH];
            OFF_IEN_LO: rdata = ien_q[LO_WIDTH-1:0];
            OFF_IEN_HI: rdata[HI_W-1:0] = ien_q[NUM_IO-1:LO_WIDTH];
            OFF_IST_LO: rdata = ist_q[LO_WIDTH-1:0];
            OFF_IST_HI: rdata[HI_W-1:0] = ist_q[NUM_IO-1:LO_WIDTH];
            OFF_ID:     rdata = GPIO_ID;
            default: ;
        endcase
    end

    // Bus handshake, register state and the registered interrupt line.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            out_q <= OUT_RST_VAL;
            oeb_q <= OEB_RST_VAL;
            ien_q <= '0;
            ist_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= req;
            dat_q <= (req && !wbs_we_i) ? rdata : '0;
            out_q <= out_next;
            oeb_q <= oeb_next;
            ien_q <= ien_next;
            ist_q <= ist_next;
            irq_q <= |(ist_next & ien_next);
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = out_q;
    assign io_oeb    = oeb_q;
    assign user_irq  = {2'b00, irq_q};

endmodule

// File: tb/tb_wb_gpio_slave.sv
// Self-checking bench for wb_gpio_slave: directed scenarios plus randomized
// register traffic compared against a register-level model of the GPIO block.
module tb_wb_gpio_slave;
    import wb_gpio_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic [37:0] io_in = '0;
    logic [37:0] io_out, io_oeb;
    logic [2:0]  irq;

    int vectors = 0;
    int miscompares = 0;

    logic [37:0] m_out, m_oeb, m_ien, m_ist;

    wb_gpio_slave dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .user_irq   (irq)
    );

    always #5 clk = ~clk;

    // Register-level model of the block's programmer-visible state.
    function automatic void model_reset();
        m_out = '0;
        m_oeb = '1;
        m_ien = '0;
        m_ist = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            8'h00: return m_out[31:0];
            8'h04: return {26'd0, m_out[37:32]};
            8'h08: return m_oeb[31:0];
            8'h0C: return {26'd0, m_oeb[37:32]};
            8'h10: return io_in[31:0];
            8'h14: return {26'd0, io_in[37:32]};
            8'h18: return m_ien[31:0];
            8'h1C: return {26'd0, m_ien[37:32]};
            8'h20: return m_ist[31:0];
            8'h24: return {26'd0, m_ist[37:32]};
            8'h28: return 32'h4750_494F;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                case (off)
                    8'h00: m_out[8*b +: 8] = d[8*b +: 8];
                    8'h08: m_oeb[8*b +: 8] = d[8*b +: 8];
                    8'h18: m_ien[8*b +: 8] = d[8*b +: 8];
                    8'h20: m_ist[8*b +: 8] = m_ist[8*b +: 8] & ~d[8*b +: 8];
                    8'h04: if (b == 0) m_out[37:32] = d[5:0];
                    8'h0C: if (b == 0) m_oeb[37:32] = d[5:0];
                    8'h1C: if (b == 0) m_ien[37:32] = d[5:0];
                    8'h24: if (b == 0) m_ist[37:32] = m_ist[37:32] & ~d[5:0];
                    default: ;
                endcase
            end
        end
    endfunction

    // One Wishbone transfer with a 16-cycle ack budget; lat counts edges to ack.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           output logic [31:0] rd, output logic acked, output int lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        acked = 1'b0; lat = 0; rd = '0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1; lat = i; rd = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic ak; int lat;
        io_in = '0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        vectors++;
        if (ack !== 1'b0 || dat_o !== 32'd0 || irq !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: ack=%0b dat=%h irq=%b, required 0/0/0", ack, dat_o, irq);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        vectors++;
        if (io_out !== 38'd0 || io_oeb !== {38{1'b1}}) begin
            miscompares++;
            $display("[TB] FAIL reset_pads: io_out=%h io_oeb=%h, required 0/3fffffffff", io_out, io_oeb);
        end
        for (int a = 0; a <= 'h2C; a += 4) begin
            wb_xfer(1'b0, BASE | 32'(a), 4'hF, 32'd0, rd, ak, lat);
            vectors++;
            if (!ak || lat != 1 || rd !== model_read(8'(a))) begin
                miscompares++;
                $display("[TB] FAIL reset_read_%02h: ack=%0b lat=%0d data=%h, required ack lat 1 data %h",
                         a, ak, lat, rd, model_read(8'(a)));
            end
        end
    endtask

    task automatic test_byte_select();
        logic [31:0] rd; logic ak; int lat;
        wb_xfer(1'b1, BASE | 32'h00, 4'b0011, 32'hA5A5_1234, rd, ak, lat);
        model_write(8'h00, 32'hA5A5_1234, 4'b0011);
        vectors++;
        if (io_out[31:0] !== 32'h0000_1234) begin
            miscompares++;
            $display("[TB] FAIL sel_io_out: got %h, required 00001234", io_out[31:0]);
        end
        wb_xfer(1'b0, BASE | 32'h00, 4'hF, 32'd0, rd, ak, lat);
        vectors++;
        if (rd !== 32'h0000_1234) begin
            miscompares++;
            $display("[TB] FAIL sel_readback: got %h, required 00001234", rd);
        end
    endtask

    task automatic test_outside_window();
        logic [31:0] rd; logic ak; int lat;
        wb_xfer(1'b1, 32'h3000_0100, 4'hF, 32'hFFFF_FFFF, rd, ak, lat);
        vectors++;
        if (ak !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL outside_ack: acked=%0b after %0d cycles, required no ack", ak, lat);
        end
        wb_xfer(1'b0, BASE | 32'h00, 4'hF, 32'd0, rd, ak, lat);
        vectors++;
        if (rd !== model_read(8'h00)) begin
            miscompares++;
            $display("[TB] FAIL outside_nochange: got %h, required %h", rd, model_read(8'h00));
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int bad_data = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h28; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                pulses++;
                if (dat_o !== 32'h4750_494F) bad_data++;
            end else if (dat_o !== 32'd0) begin
                bad_data++;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("[TB] FAIL held_stb_pulses: got %0d, required 3", pulses);
        end
        vectors++;
        if (bad_data != 0) begin
            miscompares++;
            $display("[TB] FAIL held_stb_data: %0d bad samples, required 0", bad_data);
        end
    endtask

    task automatic test_random_regs();
        logic [31:0] rd, d; logic ak; int lat;
        logic [7:0] offs[12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                                 8'h18, 8'h1C, 8'h20, 8'h28, 8'h2C, 8'hF0};
        logic [7:0] wo, ro;
        logic [3:0] s;
        for (int n = 0; n < 30; n++) begin
            wo = offs[$urandom_range(0, 11)];
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            wb_xfer(1'b1, BASE | 32'(wo), s, d, rd, ak, lat);
            model_write(wo, d, s);
            vectors++;
            if (!ak || lat != 1) begin
                miscompares++;
                $display("[TB] FAIL rand_wr_ack_%02h: ack=%0b lat=%0d, required ack lat 1", wo, ak, lat);
            end
            ro = offs[$urandom_range(0, 11)];
            wb_xfer(1'b0, BASE | 32'(ro), 4'hF, 32'd0, rd, ak, lat);
            vectors++;
            if (rd !== model_read(ro)) begin
                miscompares++;
                $display("[TB] FAIL rand_rd_%02h: got %h, required %h", ro, rd, model_read(ro));
            end
            vectors++;
            if (io_out !== m_out || io_oeb !== m_oeb) begin
                miscompares++;
                $display("[TB] FAIL rand_pads: out=%h oeb=%h, required %h %h", io_out, io_oeb, m_out, m_oeb);
            end
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic ak; int lat;
        wb_xfer(1'b1, BASE | 32'h18, 4'hF, 32'h1, rd, ak, lat);
        model_write(8'h18, 32'h1, 4'hF);
        wb_xfer(1'b1, BASE | 32'h1C, 4'hF, 32'h0, rd, ak, lat);
        model_write(8'h1C, 32'h0, 4'hF);
        io_in[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (irq !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL irq_early: got %b, required 000", irq);
        end
        @(posedge clk); #1;
        m_ist[0] = 1'b1;
        vectors++;
        if (irq !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL irq_raise: got %b, required 001", irq);
        end
        wb_xfer(1'b0, BASE | 32'h10, 4'hF, 32'd0, rd, ak, lat);
        vectors++;
        if (rd !== model_read(8'h10)) begin
            miscompares++;
            $display("[TB] FAIL irq_in_lo: got %h, required %h", rd, model_read(8'h10));
        end
        wb_xfer(1'b0, BASE | 32'h20, 4'hF, 32'd0, rd, ak, lat);
        vectors++;
        if (rd !== model_read(8'h20)) begin
            miscompares++;
            $display("[TB] FAIL irq_ist_lo: got %h, required %h", rd, model_read(8'h20));
        end
        wb_xfer(1'b1, BASE | 32'h20, 4'hF, 32'h1, rd, ak, lat);
        model_write(8'h20, 32'h1, 4'hF);
        vectors++;
        if (irq !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL irq_clear: got %b, required 000", irq);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] rd; logic ak; int lat;
        wb_xfer(1'b1, BASE | 32'h1C, 4'hF, 32'h2, rd, ak, lat);
        model_write(8'h1C, 32'h2, 4'hF);
        io_in[33] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb_xfer(1'b1, BASE | 32'h24, 4'b0001, 32'h2, rd, ak, lat);
        model_write(8'h24, 32'h2, 4'b0001);
        m_ist[33] = 1'b1;
        wb_xfer(1'b0, BASE | 32'h24, 4'hF, 32'd0, rd, ak, lat);
        vectors++;
        if (rd !== model_read(8'h24)) begin
            miscompares++;
            $display("[TB] FAIL set_wins_ist: got %h, required %h", rd, model_read(8'h24));
        end
        vectors++;
        if (irq !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL set_wins_irq: got %b, required 001", irq);
        end
        wb_xfer(1'b1, BASE | 32'h1C, 4'hF, 32'h0, rd, ak, lat);
        model_write(8'h1C, 32'h0, 4'hF);
        wb_xfer(1'b0, BASE | 32'h24, 4'hF, 32'd0, rd, ak, lat);
        vectors++;
        if (rd !== model_read(8'h24) || irq !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL ien_off_keeps_ist: ist=%h irq=%b, required %h 000", rd, irq, model_read(8'h24));
        end
        wb_xfer(1'b1, BASE | 32'h24, 4'hF, 32'h2, rd, ak, lat);
        model_write(8'h24, 32'h2, 4'hF);
        wb_xfer(1'b0, BASE | 32'h24, 4'hF, 32'd0, rd, ak, lat);
        vectors++;
        if (rd !== model_read(8'h24)) begin
            miscompares++;
            $display("[TB] FAIL ist_hi_clear: got %h, required %h", rd, model_read(8'h24));
        end
    endtask

    task automatic test_arm_and_reset();
        logic [31:0] rd; logic ak; int lat;
        io_in[5] = 1'b1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_xfer(1'b1, BASE | 32'h18, 4'hF, 32'h21, rd, ak, lat);
        model_write(8'h18, 32'h21, 4'hF);
        repeat (5) begin @(posedge clk); #1; end
        wb_xfer(1'b0, BASE | 32'h20, 4'hF, 32'd0, rd, ak, lat);
        vectors++;
        if (rd !== model_read(8'h20) || irq !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL arm_mask: ist=%h irq=%b, required %h 000", rd, irq, model_read(8'h20));
        end
        // Reset arriving while a write is waiting for its ack.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE | 32'h00; sel = 4'hF; wdat = 32'hFFFF_FFFF;
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        vectors++;
        if (ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_pending_ack: got %0b, required 0", ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_xfer(1'b0, BASE | 32'h00, 4'hF, 32'd0, rd, ak, lat);
        vectors++;
        if (rd !== model_read(8'h00) || io_out !== m_out) begin
            miscompares++;
            $display("[TB] FAIL reset_pending_reg: reg=%h pads=%h, required %h", rd, io_out, model_read(8'h00));
        end
        // Reset arriving while ack is already high must drop it at once.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h28; sel = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ack !== 1'b0 || dat_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_async_ack: ack=%0b dat=%h, required 0/0", ack, dat_o);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_byte_select();
        test_outside_window();
        test_back_to_back();
        test_random_regs();
        test_irq();
        test_set_wins();
        test_arm_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_gpio_slave.md
Name: wb_gpio_slave

Overview:
- Wishbone classic slave that sits directly downstream of the user project wrapper's Wishbone port.
- Exposes the 38 user IOs through memory-mapped registers: output data, output-enable, synchronised input and rising-edge interrupts.
- Drives io_out/io_oeb and user_irq back up through the wrapper.

Parameters:
- BASE_ADDR, 32'h3000_0000, slave base; hit when wbs_adr_i[31:8] == BASE_ADDR[31:8].
- NUM_IO, 38, number of user IOs handled (fixed 38 for the top level; lo word = bits 31:0, hi word = bits NUM_IO-1:32).
- SYNC_STAGES, 2, flop stages on io_in before use.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_n_i  in  1  reset; asynchronous, active-low.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- io_in  in  NUM_IO  pad inputs (asynchronous to wb_clk_i).
- io_out  out  NUM_IO  pad output data.
- io_oeb  out  NUM_IO  pad output enable, active-low.
- user_irq  out  3  interrupts to the management core.

Behaviour:
- Register map, offset = wbs_adr_i[7:0]:
  - 0x00 OUT_LO RW.
  - 0x04 OUT_HI RW [5:0].
  - 0x08 OEB_LO RW.
  - 0x0C OEB_HI RW [5:0].
  - 0x10 IN_LO RO.
  - 0x14 IN_HI RO.
  - 0x18 IEN_LO RW.
  - 0x1C IEN_HI RW.
  - 0x20 IST_LO W1C.
  - 0x24 IST_HI W1C.
  - 0x28 ID RO = 32'h4750_494F.
- Unused upper bits of HI registers read 0 and ignore writes.
- Unmapped offsets inside the 256-byte window: ack, read 0, write ignored.
- Address outside the window: no ack, no state change. Other slaves own that space.
- Handshake:
  - req = cyc & stb & hit & ~ack_q.
  - ack_q is a flop: set on req, cleared the following cycle.
  - ack is exactly 1 cycle wide, latency 1 cycle after stb is first sampled.
  - Master holding stb across transfers gets ack every second cycle.
  - wbs_dat_o is registered and valid only while ack is high; 0 otherwise.
- Writes commit on the clock edge that samples req. Each byte lane is written only if its wbs_sel_i bit is set. W1C honours sel per byte.
- Input path:
  - io_in passes through SYNC_STAGES flops, then a prev flop.
  - rise = sync & ~prev.
  - IN_* return the synchronised value.
- Edge arming: a 2-bit counter after reset release masks rise for 3 cycles, so pins already high at reset never raise status.
- Status:
  - ist_next = (ist & ~w1c_clear) | (rise & ien & armed).
  - Set wins over a simultaneous W1C clear of the same bit.
  - Clearing IEN does not clear pending status.
- Interrupts:
  - user_irq[0] = |(ist & ien), driven from flops (no combinational path from the bus).
  - user_irq[2:1] = 0.
- Reset values: io_out 0, io_oeb all 1 (all pads input), ien 0, ist 0, sync/prev 0, arm counter 0, wbs_ack_o 0, wbs_dat_o 0, user_irq 0.
- Reset asserted mid-transfer: ack and all state clear immediately (asynchronous). The transfer is dropped and the master must retry.
- io_out/io_oeb follow their registers with 1-cycle latency from the write edge; no glitching (driven straight from flops).

Decomposition:
- Package wb_gpio_pkg holds:
  - register offset localparams;
  - the ID constant;
  - reset values (OEB reset = all ones);
  - the lo/hi width split derived from NUM_IO.
- One sub-module: gpio_sync_edge (parameters WIDTH, STAGES).
  - Contains the synchroniser chain, prev flop, arm counter and rise output.
  - Instantiated once with WIDTH = NUM_IO.

Test Plan:
- Reset, then read all registers → OEB_LO = 32'hFFFF_FFFF, OEB_HI = 32'h3F, ID = 32'h4750_494F, others 0; ack 1 cycle after stb each time.
- Write OUT_LO = 32'hA5A5_1234 with sel = 4'b0011 → io_out[15:0] = 16'h1234, io_out[31:16] stays 0; readback 32'h0000_1234.
- Write to 0x3000_0100 (outside window) → no ack for 16 cycles, no register change. Hold stb on a valid read for 6 cycles → exactly 3 ack pulses.
- IEN_LO = 1; raise io_in[0] → IN_LO bit0 = 1 and IST_LO bit0 = 1 after SYNC_STAGES+1 cycles, user_irq[0] = 1. Write IST_LO = 1 → user_irq[0] = 0 next cycle.
- Rising edge on io_in[33] in the same cycle as a W1C of IST_HI bit1 (IEN_HI bit1 = 1) → status stays 1.
- Hold io_in[5] = 1 through reset release with IEN enabled → IST stays 0. Assert reset during a pending write → no ack, register still at its reset value.
